// File: rtl/mips32_prog_loader_if.sv
// Byte-stream handshake into the program loader.
// The master drives valid/data; the loader returns ready.
interface mips32_prog_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/mips32_prog_loader.sv
// Boot loader: length header plus big-endian words into imem, then starts the core.
// Define MIPS32_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module mips32_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input  logic                clk1,
  input  logic                rst_n,
  mips32_prog_loader_if.slave s,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_halt,
  output logic                cpu_start,
  output logic                done,
  output logic                error,
  output logic [ADDR_W:0]     words_loaded
);

`ifdef MIPS32_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, LOAD, CSUM, DONE, ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    HDR_HI, HDR_LO, LOAD, DONE, ERROR
  } state_t;
`endif

  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_hi;
  logic [15:0]       r_n;
  logic [23:0]       r_word;
  logic [1:0]        r_idx;
  logic              r_we;
  logic              r_start;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_cnt;
  logic              w_xfer;
  logic              w_last;
  logic [15:0]       w_n;
  state_t            w_fin;
`ifdef MIPS32_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  // Ready is gated by rst_n so it is low throughout the reset cycle.
  always_comb begin
    s.s_ready = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        HDR_HI, HDR_LO, LOAD: s.s_ready = 1'b1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        CSUM:                 s.s_ready = 1'b1;
`endif
        default:              s.s_ready = 1'b0;
      endcase
    end
  end

  assign w_xfer = s.s_valid && s.s_ready;
  assign w_n    = {r_hi, s.s_data};
  assign w_last = (32'(r_cnt) + 32'd1) == 32'(r_n);
`ifdef MIPS32_LOADER_CHECKSUM_EN
  assign w_fin  = CSUM;
`else
  assign w_fin  = DONE;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HDR_HI: if (w_xfer) w_next = HDR_LO;
      HDR_LO: begin
        if (w_xfer) begin
          if (w_n == 16'd0)
            w_next = w_fin;
          else if (32'(w_n) > 32'(MAX_WORDS))
            w_next = ERROR;
          else
            w_next = LOAD;
        end
      end
      LOAD: begin
        if (w_xfer && r_idx == 2'd3 && w_last)
          w_next = w_fin;
      end
`ifdef MIPS32_LOADER_CHECKSUM_EN
      CSUM: begin
        if (w_xfer)
          w_next = (s.s_data == r_csum) ? DONE : ERROR;
      end
`endif
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_state <= HDR_HI;
      r_hi    <= '0;
      r_n     <= '0;
      r_word  <= '0;
      r_idx   <= '0;
      r_we    <= 1'b0;
      r_start <= 1'b0;
      r_addr  <= ADDR_W'(BASE_ADDR);
      r_wdata <= '0;
      r_cnt   <= '0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_we    <= 1'b0;
      r_start <= (w_next == DONE) && (r_state != DONE);
      if (w_xfer) begin
        unique case (r_state)
          HDR_HI: r_hi <= s.s_data;
          HDR_LO: r_n  <= w_n;
          LOAD: begin
            r_word <= {r_word[15:0], s.s_data};
            r_idx  <= r_idx + 2'd1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ s.s_data;
`endif
            if (r_idx == 2'd3) begin
              r_we    <= 1'b1;
              r_wdata <= {r_word, s.s_data};
              r_addr  <= ADDR_W'(BASE_ADDR) + r_cnt[ADDR_W-1:0];
              r_cnt   <= r_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_we       = r_we;
  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign cpu_start    = r_start;
  assign cpu_halt     = (r_state != DONE);
  assign done         = (r_state == DONE);
  assign error        = (r_state == ERROR);
  assign words_loaded = r_cnt;

endmodule
